acc_bias_relu: RTL
==================

// Module: acc_bias_relu
// PURPOSE
//  Downstream stage of the fixed-point multiplier (signed Q(IW).(FW), 1-cycle latency).
//  Accumulates one packet of products (one output pixel: K*K*C terms, end marked by in_last).
//  Adds a per-channel bias, applies optional ReLU and saturates back to IW+FW bits.
//  Presents the result to the next stage with a valid/ready handshake.
// PARAMETERS
//  IW     24  integer bits of data/bias/result (same as multiplier)
//  FW     8   fraction bits (same as multiplier); DW = IW+FW = 32
//  GW     8   accumulator guard bits; AW = DW+GW = 40
//  CNT_W  16  width of the beat counter
// PORTS
//  clk        in   1      clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      product beat valid
//  in_data    in   DW     signed product from multiplier, QIW.FW
//  in_last    in   1      marks final beat of packet; qualified by in_valid
//  in_ready   out  1      stage can accept a beat
//  bias       in   DW     signed bias, QIW.FW; sampled on first beat of packet
//  relu_en    in   1      1 = clamp negatives to 0; sampled with in_last beat
//  out_valid  out  1      result valid
//  out_data   out  DW     signed result, QIW.FW
//  out_sat    out  1      result was saturated (qualified by out_valid)
//  out_cnt    out  CNT_W  number of beats in the packet (qualified by out_valid)
//  out_ready  in   1      downstream accepts result
// BEHAVIOUR
//  - Reset: state=ACC, acc=0, first=1, cnt=0, out_valid=0, out_data=0, out_sat=0, out_cnt=0.
//    Reset mid-packet discards partial sums; no output produced for that packet.
//  - States: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
//  - ACC, beat accepted (in_valid=1):
//    - first=1: acc <= sext(bias)+sext(in_data), cnt<=1, first<=0.
//    - first=0: acc <= acc+sext(in_data), cnt<=cnt+1.
//    - Sign-extend every operand to AW. No rounding or shifting: all terms are already QIW.FW.
//  - Beat with in_last=1: final sum s = (first ? bias : acc) + in_data.
//    - Saturate s to [-2^(DW-1), 2^(DW-1)-1]; out_sat=1 iff clipped.
//    - If relu_en and the saturated value < 0: out_data=0, out_sat unchanged.
//    - Register the result; out_valid=1 on the next cycle (1-cycle latency from last beat).
//    - out_cnt=cnt+1 (1 for a single-beat packet). State -> OUT, first<=1.
//  - OUT:
//    - out_data/out_sat/out_cnt held stable until out_valid&out_ready.
//    - in_valid is ignored (in_ready=0).
//    - On handshake: out_valid<=0, state -> ACC next cycle.
//    - Handshake in the same cycle as new in_valid: the beat is not taken (in_ready was 0).
//  - in_valid=0 cycles (bubbles) inside a packet: acc/cnt hold; the result is independent of gaps.
//  - cnt wraps at 2^CNT_W (no flag). Accumulator overflow beyond AW is unchecked:
//    packets are limited to 2^GW full-scale terms.
//  - in_last without in_valid has no effect. An empty packet is impossible by construction.
// STRUCTURE
//  - rvgg_pkg:
//    - IW/FW/DW defaults, function sext_acc(), state enum {ACC, OUT}.
//    - Shared with the multiplier and the pooling stage.
//  - One sub-module: sat_relu (combinational).
//    - AW-bit sum and relu_en in -> DW-bit value plus sat flag out.
//    - Reused later by the residual-add stage.
//  - Top holds the FSM, accumulator, counter and output register.
// TESTING
//  1. 9 beats in_data=32'h100 (1.0), bias=32'h80, relu_en=1, out_ready=1
//     -> out_data=32'h980, out_cnt=9, out_sat=0, out_valid 1 cycle after last beat, for 1 cycle.
//  2. 3 beats 32'hFFFFFE00 (-2.0), bias=0: relu_en=1 -> out_data=0;
//     repeat with relu_en=0 -> 32'hFFFFFA00.
//  3. 2 beats 32'h7FFFFFFF, bias=32'h7FFFFFFF, relu_en=0 -> out_data=32'h7FFFFFFF, out_sat=1.
//     Negative mirror -> 32'h80000000, out_sat=1.
//  4. out_ready=0 for 5 cycles during OUT with in_valid=1 driven
//     -> out_data stable, in_ready=0, no beats consumed.
//     After release, next packet (1 beat 32'h100, bias 0) -> 32'h100.
//  5. rst pulse after 4 beats of a packet -> out_valid=0 during and after reset.
//     Next packet of 1 beat 32'h200, bias 32'h100 -> 32'h300, out_cnt=1.
//  6. Test 1 packet with random in_valid bubbles and a single-beat in_last packet
//     -> results identical to the gap-free run.

Source files
------------

// File: rtl/rvgg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rvgg_pkg : shared fixed-point widths, sign-extension helper, stage FSM   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package rvgg_pkg;

  localparam int C_IW = 24;
  localparam int C_FW = 8;
  localparam int C_DW = C_IW + C_FW;
  localparam int C_GW = 8;
  localparam int C_AW = C_DW + C_GW;

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  function automatic logic [C_AW-1:0] sext_acc(input logic [C_DW-1:0] x);
    return {{C_GW{x[C_DW-1]}}, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_bias_relu_sat_relu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_relu : clip an AW-bit signed sum to DW bits, optional ReLU clamp     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sat_relu
  import rvgg_pkg::*;
#(
  parameter int DW = C_DW,
  parameter int AW = C_AW
) (
  input  logic [AW-1:0] i_sum,
  input  logic          i_relu_en,
  output logic [DW-1:0] o_data,
  output logic          o_sat
);

  logic [AW-DW:0] w_top;
  logic           w_fits;
  logic [DW-1:0]  w_clip;

  // The sum fits iff every bit from the DW sign position upward agrees.
  assign w_top  = i_sum[AW-1:DW-1];
  assign w_fits = (&w_top) | ~(|w_top);

  always_comb begin
    w_clip = i_sum[DW-1:0];
    if (!w_fits) begin
      w_clip = i_sum[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  assign o_sat  = ~w_fits;
  assign o_data = (i_relu_en && w_clip[DW-1]) ? '0 : w_clip;

endmodule
`default_nettype wire

// File: rtl/acc_bias_relu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | acc_bias_relu : packet accumulator + bias + ReLU + saturation, with      |
// |                 valid/ready result output                                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module acc_bias_relu
  import rvgg_pkg::*;
#(
  parameter int IW    = C_IW,
  parameter int FW    = C_FW,
  parameter int GW    = C_GW,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IW+FW-1:0]    in_data,
  input  logic                in_last,
  output logic                in_ready,
  input  logic [IW+FW-1:0]    bias,
  input  logic                relu_en,
  output logic                out_valid,
  output logic [IW+FW-1:0]    out_data,
  output logic                out_sat,
  output logic [CNT_W-1:0]    out_cnt,
  input  logic                out_ready
);

  localparam int DW = IW + FW;
  localparam int AW = DW + GW;

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic             r_first;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_out_cnt;

  logic [AW-1:0]    w_base;
  logic [AW-1:0]    w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DW-1:0]    w_res;
  logic             w_res_sat;

  // Bias enters on the first beat, so the sum path covers both first and later beats.
  assign w_base    = r_first ? {{GW{bias[DW-1]}}, bias} : r_acc;
  assign w_sum     = w_base + {{GW{in_data[DW-1]}}, in_data};
  assign w_cnt_nxt = r_first ? CNT_W'(1) : r_cnt + CNT_W'(1);

  sat_relu #(
    .DW (DW),
    .AW (AW)
  ) u_sat_relu (
    .i_sum     (w_sum),
    .i_relu_en (relu_en),
    .o_data    (w_res),
    .o_sat     (w_res_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_cnt   <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (in_valid) begin
            r_cnt <= w_cnt_nxt;
            if (in_last) begin
              r_out_data  <= w_res;
              r_out_sat   <= w_res_sat;
              r_out_cnt   <= w_cnt_nxt;
              r_out_valid <= 1'b1;
              r_first     <= 1'b1;
              r_state     <= OUT;
            end else begin
              r_acc   <= w_sum;
              r_first <= 1'b0;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign in_ready  = (r_state == ACC);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_cnt   = r_out_cnt;

endmodule
`default_nettype wire
